// File: rtl/i2s_tdm_clkgen.sv
// I2S/TDM bit-clock and frame-sync generator: divided SCK, WS in four sync modes,
// per-edge strobes and frame position, with frame-boundary config latching and graceful stop.
module i2s_tdm_clkgen #(
   parameter  int DIV_WIDTH     = 16,
   parameter  int SLOT_BITS_MAX = 32,
   parameter  int SLOTS_MAX     = 8,
   localparam int SBW           = $clog2(SLOT_BITS_MAX),
   localparam int SLW           = $clog2(SLOTS_MAX)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 pol_i,
   input  logic                 ws_pol_i,
   input  logic [1:0]           mode_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   input  logic [SBW-1:0]       slot_bits_i,
   input  logic [SLW-1:0]       slots_i,
   output logic                 sck_o,
   output logic                 ws_o,
   output logic                 sample_o,
   output logic                 launch_o,
   output logic                 frame_start_o,
   output logic [SLW-1:0]       slot_o,
   output logic [SBW-1:0]       bit_o,
   output logic                 busy_o
);

   localparam int PW = SBW + SLW + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] STOP = 2'd2;

   logic [1:0]           state;
   logic [DIV_WIDTH-1:0] cnt, div_q;
   logic [1:0]           mode_q;
   logic [SBW-1:0]       sb_q, nxt_bit;
   logic [SLW-1:0]       sl_q, nxt_slot;
   logic                 pol_q, last, ws_nxt, ws_first;

   // Raw frame-sync level for a position given as (slot, bit) under a config.
   function automatic logic ws_raw(input logic [1:0] m, input logic [SLW-1:0] s,
                                   input logic [SBW-1:0] b, input logic [SBW-1:0] sb,
                                   input logic [SLW-1:0] sl);
      logic [PW-1:0] len, p, f, pn;
      len = PW'(sb) + PW'(1);
      p   = PW'(s) * len + PW'(sb - b);
      f   = (PW'(sl) + PW'(1)) * len;
      pn  = (p + PW'(1) == f) ? '0 : p + PW'(1);
      case (m)
         2'b00:   ws_raw = pn >= (f >> 1);
         2'b01:   ws_raw = p >= (f >> 1);
         2'b10:   ws_raw = p == f - PW'(1);
         default: ws_raw = p < len;
      endcase
   endfunction

   always_comb begin
      last     = (bit_o == '0) && (slot_o == sl_q);
      nxt_bit  = (bit_o == '0) ? sb_q : bit_o - SBW'(1);
      nxt_slot = (bit_o == '0) ? slot_o + SLW'(1) : slot_o;
      ws_nxt   = ws_pol_i ^ ws_raw(mode_q, nxt_slot, nxt_bit, sb_q, sl_q);
      // Position 0 of a frame that starts with the live inputs as its config.
      ws_first = ws_pol_i ^ ws_raw(mode_i, '0, slot_bits_i, slot_bits_i, slots_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         cnt           <= '0;
         div_q         <= '0;
         mode_q        <= '0;
         sb_q          <= '0;
         sl_q          <= '0;
         pol_q         <= 1'b0;
         sck_o         <= 1'b0;
         ws_o          <= 1'b0;
         sample_o      <= 1'b0;
         launch_o      <= 1'b0;
         frame_start_o <= 1'b0;
         slot_o        <= '0;
         bit_o         <= '0;
         busy_o        <= 1'b0;
      end else begin
         sample_o      <= 1'b0;
         launch_o      <= 1'b0;
         frame_start_o <= 1'b0;
         if (state == IDLE) begin
            sck_o  <= pol_i;
            ws_o   <= ws_pol_i;
            slot_o <= '0;
            bit_o  <= slot_bits_i;
            if (en_i) begin
               state         <= RUN;
               busy_o        <= 1'b1;
               frame_start_o <= 1'b1;
               ws_o          <= ws_first;
               cnt           <= div_i;
               div_q         <= div_i;
               mode_q        <= mode_i;
               sb_q          <= slot_bits_i;
               sl_q          <= slots_i;
               pol_q         <= pol_i;
            end
         end else begin
            state <= en_i ? RUN : STOP;
            if (cnt != '0) begin
               cnt <= cnt - DIV_WIDTH'(1);
            end else if (sck_o == pol_q) begin
               cnt      <= div_q;
               sck_o    <= ~pol_q;
               sample_o <= 1'b1;
            end else begin
               launch_o <= 1'b1;
               if (!last) begin
                  cnt    <= div_q;
                  sck_o  <= pol_q;
                  slot_o <= nxt_slot;
                  bit_o  <= nxt_bit;
                  ws_o   <= ws_nxt;
               end else if (state == STOP && !en_i) begin
                  // Last bit of the frame while stopping: settle straight into idle levels.
                  state  <= IDLE;
                  busy_o <= 1'b0;
                  cnt    <= '0;
                  sck_o  <= pol_i;
                  ws_o   <= ws_pol_i;
                  slot_o <= '0;
                  bit_o  <= slot_bits_i;
               end else begin
                  frame_start_o <= 1'b1;
                  cnt           <= div_i;
                  div_q         <= div_i;
                  mode_q        <= mode_i;
                  sb_q          <= slot_bits_i;
                  sl_q          <= slots_i;
                  pol_q         <= pol_i;
                  sck_o         <= pol_i;
                  ws_o          <= ws_first;
                  slot_o        <= '0;
                  bit_o         <= slot_bits_i;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_tdm_clkgen.sv
// Bench for i2s_tdm_clkgen: per-cycle comparison against a frame-arithmetic model
// (edge count -> position -> slot/bit/WS), directed scenarios plus random configs.
module tb_i2s_tdm_clkgen;
   localparam int DW  = 16;
   localparam int SBW = 5;
   localparam int SLW = 3;
   localparam int OW  = 6 + SLW + SBW;
   localparam int LI  = SBW + SLW + 1;

   logic clk = 1'b0, rst = 1'b1, en = 1'b0, pol = 1'b0, ws_pol = 1'b0;
   logic [1:0]     mode = '0;
   logic [DW-1:0]  div  = '0;
   logic [SBW-1:0] sb   = '0;
   logic [SLW-1:0] sl   = '0;
   logic sck, ws, sample, launch, fs, busy;
   logic [SLW-1:0] slot;
   logic [SBW-1:0] bitx;
   logic [OW-1:0]  obs, exp_v;

   i2s_tdm_clkgen #(.DIV_WIDTH(DW), .SLOT_BITS_MAX(32), .SLOTS_MAX(8)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .pol_i(pol), .ws_pol_i(ws_pol), .mode_i(mode),
      .div_i(div), .slot_bits_i(sb), .slots_i(sl), .sck_o(sck), .ws_o(ws), .sample_o(sample),
      .launch_o(launch), .frame_start_o(fs), .slot_o(slot), .bit_o(bitx), .busy_o(busy));

   always #5 clk = ~clk;
   assign obs = {busy, sck, ws, sample, launch, fs, slot, bitx};

   typedef struct {int dv; int md; int sbv; int slv; bit pl;} cfg_t;

   int   n_pass = 0, n_chk = 0;
   int   m_k = 0;
   bit   m_busy = 1'b0, m_enp = 1'b0;
   cfg_t m_cfg;

   function automatic int flen(cfg_t c);
      return (c.slv + 1) * (c.sbv + 1);
   endfunction

   // Frame position is simply the number of completed launch edges since frame start.
   function automatic int pos();
      return m_k / (2 * (m_cfg.dv + 1));
   endfunction

   function automatic logic [OW-1:0] predict(int k, cfg_t c, bit wp);
      int per, e, p, f;
      bit on, raw;
      per = c.dv + 1;
      e   = k / per;
      on  = (k > 0) && (k % per == 0);
      p   = e / 2;
      f   = flen(c);
      case (c.md)
         0:       raw = ((p + 1) % f) >= f / 2;
         1:       raw = p >= f / 2;
         2:       raw = p == f - 1;
         default: raw = p <= c.sbv;
      endcase
      return {1'b1, c.pl ^ e[0], wp ^ raw, on && e[0], on && !e[0], k == 0,
              SLW'(p / (c.sbv + 1)), SBW'(c.sbv - p % (c.sbv + 1))};
   endfunction

   function automatic logic [OW-1:0] idle_val(bit l);
      return {1'b0, pol, ws_pol, 1'b0, l, 1'b0, SLW'(0), sb};
   endfunction

   function automatic cfg_t cur_cfg();
      cfg_t c;
      c.dv = int'(div); c.md = int'(mode); c.sbv = int'(sb); c.slv = int'(sl); c.pl = pol;
      return c;
   endfunction

   // Advance one cycle and derive the expected outputs from the inputs the DUT just sampled.
   task automatic tick();
      @(negedge clk);
      if (rst) begin
         exp_v  = '0;
         m_busy = 1'b0;
      end else if (!m_busy) begin
         if (en) begin
            m_busy = 1'b1; m_k = 0; m_cfg = cur_cfg();
            exp_v  = predict(0, m_cfg, ws_pol);
         end else exp_v = idle_val(1'b0);
      end else begin
         m_k++;
         if (m_k == 2 * (m_cfg.dv + 1) * flen(m_cfg)) begin
            if (!en && !m_enp) begin
               m_busy = 1'b0;
               exp_v  = idle_val(1'b1);
            end else begin
               m_k = 0; m_cfg = cur_cfg();
               exp_v = predict(0, m_cfg, ws_pol);
               exp_v[LI] = 1'b1;
            end
         end else exp_v = predict(m_k, m_cfg, ws_pol);
      end
      m_enp = en;
   endtask

   task automatic set_cfg(int d, int m, int s, int l, bit p, bit wp);
      div = DW'(d); mode = 2'(m); sb = SBW'(s); sl = SLW'(l); pol = p; ws_pol = wp;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1;
      repeat (2) begin
         tick();
         if (obs !== exp_v) $display("FAIL reset got=%h exp=%h", obs, exp_v); else n_pass++;
         n_chk++;
      end
      rst = 1'b0; en = 1'b0;
      repeat (2) begin
         tick();
         if (obs !== exp_v) $display("FAIL reset_idle got=%h exp=%h", obs, exp_v); else n_pass++;
         n_chk++;
      end
   endtask

   task automatic test_i2s(bit p, bit wp);
      test_reset();
      set_cfg(1, 0, 15, 1, p, wp);
      tick();
      if (obs !== exp_v) $display("FAIL i2s_idle_pol got=%h exp=%h", obs, exp_v); else n_pass++;
      n_chk++;
      en = 1'b1;
      repeat (2 * 128 + 8) begin
         tick();
         if (obs !== exp_v) $display("FAIL i2s k=%0d got=%h exp=%h", m_k, obs, exp_v); else n_pass++;
         n_chk++;
      end
   endtask

   task automatic test_dsp_short();
      test_reset();
      set_cfg(0, 2, 31, 7, 1'b0, 1'b0);
      en = 1'b1;
      repeat (2 * 256 + 20) begin
         tick();
         if (obs !== exp_v) $display("FAIL dsp_short k=%0d got=%h exp=%h", m_k, obs, exp_v); else n_pass++;
         n_chk++;
      end
   endtask

   task automatic test_latching();
      test_reset();
      set_cfg(1, 0, 15, 1, 1'b0, 1'b0);
      en = 1'b1;
      repeat (40) begin
         tick();
         if (obs !== exp_v) $display("FAIL latch_old k=%0d got=%h exp=%h", m_k, obs, exp_v); else n_pass++;
         n_chk++;
      end
      div = DW'(3); mode = 2'b11;
      repeat (88 + 256 + 40) begin
         tick();
         if (obs !== exp_v) $display("FAIL latch_new k=%0d got=%h exp=%h", m_k, obs, exp_v); else n_pass++;
         n_chk++;
      end
   endtask

   task automatic test_stop();
      int n;
      test_reset();
      set_cfg(1, 1, 15, 1, 1'b0, 1'b1);
      en = 1'b1;
      for (int phase = 0; phase < 2; phase++) begin
         n = 0;
         while (!(m_busy && pos() == 10) && n < 200) begin
            tick(); n++;
            if (obs !== exp_v) $display("FAIL stop_run k=%0d got=%h exp=%h", m_k, obs, exp_v); else n_pass++;
            n_chk++;
         end
         en = 1'b0;
         if (phase == 1) begin
            n = 0;
            while (pos() != 20 && n < 200) begin
               tick(); n++;
               if (obs !== exp_v) $display("FAIL stop_cancel k=%0d got=%h exp=%h", m_k, obs, exp_v); else n_pass++;
               n_chk++;
            end
            en = 1'b1;
            repeat (200) begin
               tick();
               if (obs !== exp_v) $display("FAIL stop_resume k=%0d got=%h exp=%h", m_k, obs, exp_v); else n_pass++;
               n_chk++;
            end
            en = 1'b0;
         end
         n = 0;
         while (busy === 1'b1 && n < 500) begin
            tick(); n++;
            if (obs !== exp_v) $display("FAIL stop_drain k=%0d got=%h exp=%h", m_k, obs, exp_v); else n_pass++;
            n_chk++;
         end
         if (busy !== 1'b0) $display("FAIL stop_timeout busy=%b required=0", busy); else n_pass++;
         n_chk++;
         repeat (4) begin
            tick();
            if (obs !== exp_v) $display("FAIL stop_idle got=%h exp=%h", obs, exp_v); else n_pass++;
            n_chk++;
         end
         en = 1'b1;
      end
      en = 1'b0;
   endtask

   task automatic test_reset_mid();
      int n = 0;
      test_reset();
      set_cfg(1, 0, 15, 1, 1'b0, 1'b0);
      en = 1'b1;
      while (!(m_busy && pos() == 24) && n < 300) begin
         tick(); n++;
         if (obs !== exp_v) $display("FAIL rstmid_run k=%0d got=%h exp=%h", m_k, obs, exp_v); else n_pass++;
         n_chk++;
      end
      if (slot !== SLW'(1) || bitx !== SBW'(7))
         $display("FAIL rstmid_pos slot=%0d bit=%0d required 1/7", slot, bitx);
      else n_pass++;
      n_chk++;
      rst = 1'b1;
      tick();
      if (obs !== '0) $display("FAIL rstmid_zero got=%h required=0", obs); else n_pass++;
      n_chk++;
      rst = 1'b0; en = 1'b0;
      tick();
      if (obs !== exp_v) $display("FAIL rstmid_idle got=%h exp=%h", obs, exp_v); else n_pass++;
      n_chk++;
      en = 1'b1;
      repeat (80) begin
         tick();
         if (obs !== exp_v) $display("FAIL rstmid_restart k=%0d got=%h exp=%h", m_k, obs, exp_v); else n_pass++;
         n_chk++;
      end
      en = 1'b0;
   endtask

   task automatic test_random();
      int n, len;
      test_reset();
      for (int it = 0; it < 6; it++) begin
         set_cfg($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 31),
                 $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         en  = 1'b1;
         len = $urandom_range(20, 700);
         repeat (len) begin
            tick();
            if (obs !== exp_v) $display("FAIL rand%0d k=%0d got=%h exp=%h", it, m_k, obs, exp_v); else n_pass++;
            n_chk++;
         end
         en = 1'b0;
         n  = 0;
         while (busy === 1'b1 && n < 4000) begin
            tick(); n++;
            if (obs !== exp_v) $display("FAIL rand%0d_drain k=%0d got=%h exp=%h", it, m_k, obs, exp_v); else n_pass++;
            n_chk++;
         end
         if (busy !== 1'b0) $display("FAIL rand%0d_timeout busy=%b required=0", it, busy); else n_pass++;
         n_chk++;
         repeat (3) begin
            tick();
            if (obs !== exp_v) $display("FAIL rand%0d_idle got=%h exp=%h", it, obs, exp_v); else n_pass++;
            n_chk++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_i2s(1'b0, 1'b0);
      test_dsp_short();
      test_stop();
      test_latching();
      test_i2s(1'b1, 1'b1);
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog time=%0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
